// File: rtl/cache_pkg.sv
// Shared widths, line payload type and address-split helpers for the data cache.
package cache_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned INDEX_W   = 3;
    localparam int unsigned MEM_AW    = 8;
    localparam int unsigned TAG_W     = ADDR_W - INDEX_W - 2;
    localparam int unsigned LINES     = 1 << INDEX_W;
    localparam int unsigned MEM_WORDS = 1 << MEM_AW;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [DATA_W-1:0]  data_t;
    typedef logic [TAG_W-1:0]   tag_t;
    typedef logic [INDEX_W-1:0] idx_t;
    typedef logic [MEM_AW-1:0]  word_t;

    typedef struct packed {
        logic  valid;
        tag_t  tag;
        data_t data;
    } line_t;

    function automatic tag_t get_tag(input addr_t a);
        return a[ADDR_W-1:INDEX_W+2];
    endfunction

    function automatic idx_t get_index(input addr_t a);
        return a[INDEX_W+1:2];
    endfunction

    function automatic word_t get_word(input addr_t a);
        return a[MEM_AW+1:2];
    endfunction

endpackage

// File: rtl/cache_if.sv
// CPU-side access bus of the cache: request, write data, read data, hit and debug LEDs.
interface cache_if;
    import cache_pkg::*;

    logic  memRead;
    logic  memWrite;
    data_t value;
    addr_t address;
    data_t out;
    logic  hit;
    logic  led0;
    logic  led1;
    logic  led2;
    logic  led3;

    modport master (
        output memRead, memWrite, value, address,
        input  out, hit, led0, led1, led2, led3
    );

    modport slave (
        input  memRead, memWrite, value, address,
        output out, hit, led0, led1, led2, led3
    );
endinterface

// File: rtl/cache_backing_mem.sv
// Word-addressed backing store: combinational read, synchronous write, contents never reset.
module cache_backing_mem
    import cache_pkg::*;
(
    input  logic  clk,
    input  logic  i_we,
    input  word_t i_addr,
    input  data_t i_wdata,
    output data_t o_rdata_c
);

    data_t r_mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata_c = r_mem[i_addr];

endmodule

// File: rtl/cache_core.sv
// Direct-mapped, one-word-per-line, write-through / write-allocate data cache with
// single-cycle accesses and registered hit/data/LED status.
module cache_core
    import cache_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    cache_if.slave bus
);

    line_t r_lines [LINES];
    data_t r_out;
    logic  r_hit;
    logic  r_led1;
    logic  r_led2;

    idx_t  w_index;
    tag_t  w_tag;
    word_t w_word;
    data_t w_mem_rdata;
    logic  w_lookup_hit;

    assign w_index      = get_index(bus.address);
    assign w_tag        = get_tag(bus.address);
    assign w_word       = get_word(bus.address);
    assign w_lookup_hit = r_lines[w_index].valid && (r_lines[w_index].tag == w_tag);

    // Memory write is suppressed on a reset edge so reset never disturbs stored data.
    cache_backing_mem u_mem (
        .clk       (clk),
        .i_we      (rst_n && bus.memWrite),
        .i_addr    (w_word),
        .i_wdata   (bus.value),
        .o_rdata_c (w_mem_rdata)
    );

    // Line update and status registers; a write wins over a simultaneous read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(LINES); i++) begin
                r_lines[i].valid <= 1'b0;
            end
            r_out  <= '0;
            r_hit  <= 1'b0;
            r_led1 <= 1'b0;
            r_led2 <= 1'b0;
        end else if (bus.memWrite) begin
            r_lines[w_index] <= '{valid: 1'b1, tag: w_tag, data: bus.value};
            r_hit            <= w_lookup_hit;
            r_led1           <= !w_lookup_hit;
            r_led2           <= 1'b1;
        end else if (bus.memRead) begin
            r_hit  <= w_lookup_hit;
            r_led1 <= !w_lookup_hit;
            r_led2 <= 1'b0;
            if (w_lookup_hit) begin
                r_out <= r_lines[w_index].data;
            end else begin
                r_out            <= w_mem_rdata;
                r_lines[w_index] <= '{valid: 1'b1, tag: w_tag, data: w_mem_rdata};
            end
        end else begin
            r_hit  <= 1'b0;
            r_led1 <= 1'b0;
            r_led2 <= 1'b0;
        end
    end

    assign bus.out  = r_out;
    assign bus.hit  = r_hit;
    assign bus.led0 = r_hit;
    assign bus.led1 = r_led1;
    assign bus.led2 = r_led2;
    assign bus.led3 = r_lines[0].valid;

endmodule

// File: tb/tb_cache_core.sv
// Bench for cache_core: directed scenarios with literal expectations, then random traffic
// compared every cycle against a behavioural cache/memory model.
module tb_cache_core;
    import cache_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_if bus ();

    cache_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural model: plain arrays describing what the cache and memory must hold.
    bit          m_valid [8];
    logic [26:0] m_tag   [8];
    logic [31:0] m_data  [8];
    logic [31:0] m_mem   [256];
    logic [31:0] e_out;
    bit          e_hit, e_led1, e_led2, e_led3;
    bit          armed = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int          idx, wd;
        logic [26:0] tg;
        bit          lh;
        if (!rst_n) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            e_out  = '0;
            e_hit  = 1'b0;
            e_led1 = 1'b0;
            e_led2 = 1'b0;
            armed  = 1'b1;
        end else begin
            idx = int'(bus.address[4:2]);
            wd  = int'(bus.address[9:2]);
            tg  = bus.address[31:5];
            lh  = m_valid[idx] && (m_tag[idx] == tg);
            if (bus.memWrite) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
                m_data[idx]  = bus.value;
                m_mem[wd]    = bus.value;
                e_hit  = lh;
                e_led1 = !lh;
                e_led2 = 1'b1;
            end else if (bus.memRead) begin
                if (!lh) begin
                    m_valid[idx] = 1'b1;
                    m_tag[idx]   = tg;
                    m_data[idx]  = m_mem[wd];
                end
                e_out  = m_data[idx];
                e_hit  = lh;
                e_led1 = !lh;
                e_led2 = 1'b0;
            end else begin
                e_hit  = 1'b0;
                e_led1 = 1'b0;
                e_led2 = 1'b0;
            end
        end
        e_led3 = m_valid[0];
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(posedge clk) begin
        #1;
        if (armed) begin
            chk("cycle_outputs",
                64'({bus.out, bus.hit, bus.led0, bus.led1, bus.led2, bus.led3}),
                64'({e_out, e_hit, e_hit, e_led1, e_led2, e_led3}));
        end
    end

    task automatic cyc(input bit rst, input bit rd, input bit wr,
                       input logic [31:0] val, input logic [31:0] addr);
        @(negedge clk);
        rst_n        = rst;
        bus.memRead  = rd;
        bus.memWrite = wr;
        bus.value    = val;
        bus.address  = addr;
        model_step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] bases [4];

    initial begin
        foreach (m_mem[i]) m_mem[i] = '0;
        bus.memRead  = 1'b0;
        bus.memWrite = 1'b0;
        bus.value    = '0;
        bus.address  = '0;
        bases[0] = 32'h0000_0000;
        bases[1] = 32'hFFFF_FC00;
        bases[2] = 32'h0000_0400;
        bases[3] = 32'h1234_5800;

        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("reset_state", 64'({bus.out, bus.hit, bus.led0, bus.led1, bus.led2, bus.led3}), 64'h0);

        // 1: cold read of line 5
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0014);
        chk("s1_hit",  64'(bus.hit),  64'd0);
        chk("s1_out",  64'(bus.out),  64'd0);
        chk("s1_led1", 64'(bus.led1), 64'd1);

        // 2: conflicting tag on line 5, then re-read
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 32'hFFFF_FC14);
        chk("s2_miss", 64'({bus.hit, bus.led1}), 64'b01);
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 32'hFFFF_FC14);
        chk("s2_rehit", 64'(bus.hit), 64'd1);

        // 3: write-allocate on cold line 7
        cyc(1'b1, 1'b0, 1'b1, 32'd99, 32'hFFFF_FC1C);
        chk("s3_wr", 64'({bus.hit, bus.led2, bus.out}), {30'd0, 2'b01, 32'd0});
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 32'hFFFF_FC1C);
        chk("s3_rd1", 64'({bus.hit, bus.out}), {31'd0, 1'b1, 32'd99});
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 32'hFFFF_FC1C);
        chk("s3_rd2", 64'({bus.hit, bus.out}), {31'd0, 1'b1, 32'd99});

        // 4: cold line 1, then alias of line 7's memory word with another tag
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 32'hFFFF_FC04);
        chk("s4_cold", 64'({bus.hit, bus.out}), 64'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_001C);
        chk("s4_alias", 64'({bus.hit, bus.out}), {31'd0, 1'b0, 32'd99});

        // 5: read+write together behaves as a write
        cyc(1'b1, 1'b1, 1'b1, 32'd7, 32'h0000_0008);
        chk("s5_rw", 64'({bus.led2, bus.out}), {31'd0, 1'b1, 32'd99});
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0008);
        chk("s5_rd", 64'({bus.hit, bus.out}), {31'd0, 1'b1, 32'd7});

        // 6: mid-stream reset keeps memory, clears lines
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("s6_reset", 64'({bus.out, bus.hit, bus.led3}), 64'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0008);
        chk("s6_refill", 64'({bus.hit, bus.led3, bus.out}), {30'd0, 2'b00, 32'd7});
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0000);
        chk("s6_led3", 64'(bus.led3), 64'd1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("idle", 64'({bus.hit, bus.led1, bus.led2, bus.out}), {29'd0, 3'b000, 32'd0});

        // Random traffic over a few tags sharing low address bits.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            bit rst, rd, wr;
            rst = ($urandom_range(0, 149) != 0);
            rd  = 1'($urandom_range(0, 1));
            wr  = ($urandom_range(0, 3) == 0);
            a   = bases[$urandom_range(0, 3)] | ($urandom & 32'h0000_03FF);
            cyc(rst, rd, wr, $urandom, a);
        end

        armed = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
